sprite_fetch_arbiter: RTL
=========================

// Module: sprite_fetch_arbiter
// PURPOSE
//  Shares the single 128x32 sprite ROM (7-bit addr = {code[1:0],row[4:0]})
//  between NUM_REQ renderers: req 0 = tile-map renderer, req 1 = player sprite.
//  Round-robin grant, 2-stage pipeline: one ROM row fetched per cycle.
//  Optional horizontal mirror of the returned row. Sits between renderers and ROM.
// PARAMETERS
//  NUM_REQ     2   number of requesters (fixed 2 in this design; 1-bit RR pointer)
//  ADDR_WIDTH  7   ROM address width = CODE_W + ROW_W
//  CODE_W      2   sprite code width (0 wall, 1 floor, 2 player, 3 unused)
//  ROW_W       5   row-within-sprite width (32 rows)
//  DATA_WIDTH  32  ROM row width (1 bit per pixel)
// PORTS
//  Clk        in   1              system clock, all state on rising edge
//  Reset_n    in   1              asynchronous, active-low reset
//  req        in   NUM_REQ        fetch request per requester, held until gnt
//  code       in   NUM_REQ*CODE_W sprite code per requester, stable while req&~gnt
//  row        in   NUM_REQ*ROW_W  row index per requester, stable while req&~gnt
//  mirror     in   NUM_REQ        1 = return row bit-reversed
//  gnt        out  NUM_REQ        1-cycle grant pulse, one-hot or zero
//  rvalid     out  NUM_REQ        1-cycle data-valid pulse, one-hot or zero
//  rdata      out  DATA_WIDTH     fetched row, valid when any rvalid bit high
//  rom_addr   out  ADDR_WIDTH     to ROM addr (ROM is combinational)
//  rom_data   in   DATA_WIDTH     from ROM data
// BEHAVIOUR
//  Reset (Reset_n low, async): gnt=0, rvalid=0, rdata=0, rom_addr=0, rr_ptr=0,
//   stage-1 valid=0. Reset mid-fetch drops in-flight fetch; no rvalid afterwards.
//  Grant (combinational decision, gnt registered at edge T):
//   - only req[i] high -> grant i.
//   - both high -> grant rr_ptr; rr_ptr then = other requester.
//   - rr_ptr updates only on a grant; idle cycles leave it unchanged.
//   - gnt[i] high in cycle T+1 only; requester drops/changes req on seeing it.
//   - a requester still high after gnt is a new request (back-to-back allowed).
//  Stage 1 (edge T): rom_addr <= {code[g],row[g]}; s1_id <= g; s1_mir <= mirror[g];
//   s1_valid <= 1. With no grant rom_addr holds, s1_valid <= 0.
//  Stage 2 (edge T+1): rdata <= s1_mir ? bitrev(rom_data) : rom_data;
//   rvalid <= s1_valid ? onehot(s1_id) : 0. rdata holds when no rvalid.
//  Latency: req sampled at T -> gnt in T+1 -> rvalid/rdata in T+2 (2 cycles).
//  Throughput: 1 fetch/cycle; with both req held permanently grants alternate
//   0,1,0,1 starting at rr_ptr.
//  bitrev: rdata[k] = rom_data[DATA_WIDTH-1-k].
//  Address: code in MSBs, row in LSBs; no range check (all 128 entries legal).
//  gnt and rvalid for the same requester may be high in one cycle (pipelined).
//  No backpressure: requester must accept rvalid cycle; data is not re-sent.
// TESTING
//  1 Reset: Reset_n low mid-stream -> gnt=0,rvalid=0,rdata=0 immediately; after
//    release a single req1 (code 2,row 1) -> rvalid[1] 2 cycles later, rdata=32'h0003C000.
//  2 Single req0 code 0 row 0 -> gnt[0] next cycle, rvalid[0] after, rdata=32'hFFFFFFFF;
//    row 5 -> 32'h80000001.
//  3 Both req held 6 cycles after reset -> gnt order 0,1,0,1,0,1; rvalid order same,
//    each rdata matching its requester's {code,row}.
//  4 Mirror: req0 code 1 row 3 mirror=1 -> rdata=32'h20000004 (unmirrored 32'h20000004
//    symmetric); code 2 row 4 mirror=1 -> rdata=bitrev(32'h00099000)=32'h00099000; use
//    asymmetric scoreboard row forced via ROM model to check bit order.
//  5 Idle gaps: req1, 3 idle cycles, req0+req1 together -> rr_ptr stayed 0 -> req0 first.
//  6 Reset asserted between gnt and rvalid -> no rvalid emitted; next fetch normal.

Source files
------------

// File: rtl/sprite_fetch_arbiter.sv
// Round-robin arbiter sharing one combinational sprite ROM between two renderers.
// Grant 1 cycle after req, row data 2 cycles after req, 1 fetch/cycle, no backpressure.
module sprite_fetch_arbiter #(
  parameter int NUM_REQ    = 2,
  parameter int ADDR_WIDTH = 7,
  parameter int CODE_W     = 2,
  parameter int ROW_W      = 5,
  parameter int DATA_WIDTH = 32
) (
  input  logic                      Clk,
  input  logic                      Reset_n,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*CODE_W-1:0] code,
  input  logic [NUM_REQ*ROW_W-1:0]  row,
  input  logic [NUM_REQ-1:0]        mirror,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [NUM_REQ-1:0]        rvalid,
  output logic [DATA_WIDTH-1:0]     rdata,
  output logic [ADDR_WIDTH-1:0]     rom_addr,
  input  logic [DATA_WIDTH-1:0]     rom_data
);

  logic                  rr_ptr;
  logic                  grant_vld;
  logic                  grant_id;
  logic [CODE_W-1:0]     grant_code;
  logic [ROW_W-1:0]      grant_row;
  logic                  grant_mir;
  logic                  s1_valid;
  logic                  s1_id;
  logic                  s1_mir;
  logic [DATA_WIDTH-1:0] rom_rev;

  // Contention goes to rr_ptr; a lone requester wins regardless of the pointer.
  always_comb begin
    grant_vld = 1'b0;
    grant_id  = 1'b0;
    if (req[0] && req[1]) begin
      grant_vld = 1'b1;
      grant_id  = rr_ptr;
    end else if (req[0]) begin
      grant_vld = 1'b1;
      grant_id  = 1'b0;
    end else if (req[1]) begin
      grant_vld = 1'b1;
      grant_id  = 1'b1;
    end
  end

  always_comb begin
    grant_code = code[CODE_W-1:0];
    grant_row  = row[ROW_W-1:0];
    grant_mir  = mirror[0];
    if (grant_id) begin
      grant_code = code[2*CODE_W-1:CODE_W];
      grant_row  = row[2*ROW_W-1:ROW_W];
      grant_mir  = mirror[1];
    end
  end

  for (genvar k = 0; k < DATA_WIDTH; k++) begin : g_rev
    assign rom_rev[k] = rom_data[DATA_WIDTH-1-k];
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      rr_ptr   <= 1'b0;
      gnt      <= '0;
      rom_addr <= '0;
      s1_valid <= 1'b0;
      s1_id    <= 1'b0;
      s1_mir   <= 1'b0;
      rvalid   <= '0;
      rdata    <= '0;
    end else begin
      gnt      <= grant_vld ? (NUM_REQ'(1) << grant_id) : '0;
      s1_valid <= grant_vld;
      if (grant_vld) begin
        rr_ptr   <= ~grant_id;
        rom_addr <= {grant_code, grant_row};
        s1_id    <= grant_id;
        s1_mir   <= grant_mir;
      end
      // Stage 2: capture the ROM row addressed last cycle.
      rvalid <= s1_valid ? (NUM_REQ'(1) << s1_id) : '0;
      if (s1_valid) begin
        rdata <= s1_mir ? rom_rev : rom_data;
      end
    end
  end

endmodule
